// File: rtl/credit_input_port_if.sv
// Flit link between an upstream credit-based sender and a receiving input
// port, plus the head/route presentation toward the switch stage.
interface credit_input_port_if #(
  parameter int unsigned FLIT_W = 20
);
  logic [FLIT_W-1:0] in_flit;
  logic              in_valid;
  logic              credit_out;
  logic [FLIT_W-1:0] head_flit;
  logic              head_valid;
  logic              route_eject;
  logic              route_local;
  logic              route_remote;
  logic              head_ready;

  modport master (
    output in_flit,
    output in_valid,
    input  credit_out,
    input  head_flit,
    input  head_valid,
    input  route_eject,
    input  route_local,
    input  route_remote,
    output head_ready
  );

  modport slave (
    input  in_flit,
    input  in_valid,
    output credit_out,
    output head_flit,
    output head_valid,
    output route_eject,
    output route_local,
    output route_remote,
    input  head_ready
  );
endinterface

// File: rtl/credit_input_port.sv
// Credit-based input port: buffers incoming flits, presents the head flit with
// a decoded route request, and returns one credit pulse per freed slot.
module credit_input_port #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned FLIT_W = 20
) (
  input  logic                         clk,
  input  logic                         rst,
  credit_input_port_if.slave           link,
  input  logic [1:0]                   my_cluster,
  input  logic [1:0]                   my_local,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         overflow_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [FLIT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [OCC_W-1:0]  r_occ;
  logic              r_credit;
  logic              r_overflow;

  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_push;
  logic [FLIT_W-1:0] w_head;
  logic [1:0]        w_dst_cluster;
  logic [1:0]        w_dst_local;

  assign w_full  = (r_occ == OCC_W'(DEPTH));
  assign w_empty = (r_occ == '0);
  assign w_pop   = !w_empty && link.head_ready;
  // A pop on the same edge frees a slot, so a write into a full FIFO is legal then.
  assign w_push  = link.in_valid && (!w_full || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_occ      <= '0;
      r_credit   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_credit <= w_pop;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_occ <= r_occ + OCC_W'(1);
      end else if (w_pop && !w_push) begin
        r_occ <= r_occ - OCC_W'(1);
      end
      if (link.in_valid && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= link.in_flit;
    end
  end

  assign w_head        = r_mem[r_rd_ptr];
  assign w_dst_cluster = w_head[19:18];
  assign w_dst_local   = w_head[17:16];

  always_comb begin
    link.head_valid   = !w_empty;
    link.head_flit    = '0;
    link.route_eject  = 1'b0;
    link.route_local  = 1'b0;
    link.route_remote = 1'b0;
    if (!w_empty) begin
      link.head_flit = w_head;
      if (w_dst_cluster != my_cluster) begin
        link.route_remote = 1'b1;
      end else if (w_dst_local == my_local) begin
        link.route_eject = 1'b1;
      end else begin
        link.route_local = 1'b1;
      end
    end
  end

  assign link.credit_out = r_credit;
  assign occupancy       = r_occ;
  assign overflow_err    = r_overflow;

endmodule

// File: tb/tb_credit_input_port.sv
// Directed bench for credit_input_port with a sender-side credit counter
// used to check the credit conservation invariant each cycle.
module tb_credit_input_port;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] my_cluster;
  logic [1:0] my_local;
  logic [2:0] occupancy;
  logic       overflow_err;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int          s_credits;
  bit          inv_en;
  int unsigned n_credits;

  credit_input_port_if #(.FLIT_W(20)) link ();

  credit_input_port #(
    .DEPTH  (DEPTH),
    .FLIT_W (20)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .link         (link.slave),
    .my_cluster   (my_cluster),
    .my_local     (my_local),
    .occupancy    (occupancy),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Sender consumes a credit per write and regains one per received pulse.
  task automatic step();
    if (link.in_valid) s_credits--;
    if (link.credit_out) s_credits++;
    @(posedge clk);
    #1;
    if (inv_en) chk("credit_inv", 32'(s_credits + int'(occupancy) + int'(link.credit_out)), DEPTH);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_occ"}, 32'(occupancy), 0);
    chk({tag, "_hv"}, 32'(link.head_valid), 0);
    chk({tag, "_hf"}, 32'(link.head_flit), 0);
    chk({tag, "_cr"}, 32'(link.credit_out), 0);
    chk({tag, "_rt"}, 32'({link.route_eject, link.route_local, link.route_remote}), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    inv_en = 1'b0;
    step();
    rst = 1'b0;
    s_credits = DEPTH;
    inv_en = 1'b1;
  endtask

  task automatic fill4(input logic [19:0] base);
    link.head_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      link.in_flit  = base + 20'(i);
      link.in_valid = 1'b1;
      step();
    end
    link.in_valid = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    inv_en          = 1'b0;
    s_credits       = DEPTH;
    link.in_flit    = '0;
    link.in_valid   = 1'b0;
    link.head_ready = 1'b0;
    my_cluster      = 2'd0;
    my_local        = 2'd0;
    #1;
    check_idle("rst");
    chk("rst_ovf", 32'(overflow_err), 0);
    step();
    do_reset();

    // Single flit to this node; head_ready while empty must be ignored
    my_cluster      = 2'd1;
    my_local        = 2'd2;
    link.in_flit    = 20'h6ABCD;
    link.in_valid   = 1'b1;
    link.head_ready = 1'b1;
    step();
    link.in_valid = 1'b0;
    chk("t1_hv", 32'(link.head_valid), 1);
    chk("t1_hf", 32'(link.head_flit), 32'h6ABCD);
    chk("t1_rt", 32'({link.route_eject, link.route_local, link.route_remote}), 32'b100);
    chk("t1_occ", 32'(occupancy), 1);
    chk("t1_cr0", 32'(link.credit_out), 0);
    step();
    chk("t1_cr1", 32'(link.credit_out), 1);
    chk("t1_occ0", 32'(occupancy), 0);
    chk("t1_hv0", 32'(link.head_valid), 0);
    step();
    chk("t1_cr2", 32'(link.credit_out), 0);

    // Fill then drain in order, credits back to back
    fill4(20'h10000);
    chk("t2_occ", 32'(occupancy), 4);
    chk("t2_cr", 32'(link.credit_out), 0);
    link.head_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("t2_head", 32'(link.head_flit), 32'h10000 + 32'(i));
      step();
      chk("t2_cr", 32'(link.credit_out), 1);
      chk("t2_occ", 32'(occupancy), 32'(4 - i));
    end
    link.head_ready = 1'b0;
    step();
    chk("t2_crend", 32'(link.credit_out), 0);

    // Full FIFO with simultaneous write and pop
    fill4(20'h20000);
    link.in_flit    = 20'h20005;
    link.in_valid   = 1'b1;
    link.head_ready = 1'b1;
    step();
    link.in_valid   = 1'b0;
    link.head_ready = 1'b0;
    chk("t3_occ", 32'(occupancy), 4);
    chk("t3_ovf", 32'(overflow_err), 0);
    chk("t3_head", 32'(link.head_flit), 32'h20002);
    chk("t3_cr", 32'(link.credit_out), 1);
    step();
    chk("t3_cr0", 32'(link.credit_out), 0);

    // Write into full FIFO without pop: dropped, sticky error
    inv_en        = 1'b0;
    link.in_flit  = 20'h3FFFF;
    link.in_valid = 1'b1;
    step();
    link.in_valid = 1'b0;
    chk("t4_ovf", 32'(overflow_err), 1);
    chk("t4_occ", 32'(occupancy), 4);
    chk("t4_cr", 32'(link.credit_out), 0);
    step();
    chk("t4_ovf_sticky", 32'(overflow_err), 1);
    chk("t4_cr1", 32'(link.credit_out), 0);
    link.head_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      chk("t4_drain", 32'(link.head_flit), 32'h20000 + 32'(i));
      step();
    end
    link.head_ready = 1'b0;
    chk("t4_empty", 32'(link.head_valid), 0);
    chk("t4_ovf_hold", 32'(overflow_err), 1);
    step();

    // Route decode
    do_reset();
    chk("t5_ovf_clr", 32'(overflow_err), 0);
    my_cluster = 2'd2;
    my_local   = 2'd0;
    link.in_flit = 20'h80000; link.in_valid = 1'b1; step();
    link.in_flit = 20'hB0000; step();
    link.in_flit = 20'h00000; step();
    link.in_valid = 1'b0;
    chk("t5_eject", 32'({link.route_eject, link.route_local, link.route_remote}), 32'b100);
    link.head_ready = 1'b1;
    step();
    chk("t5_local", 32'({link.route_eject, link.route_local, link.route_remote}), 32'b010);
    step();
    chk("t5_remote", 32'({link.route_eject, link.route_local, link.route_remote}), 32'b001);
    chk("t5_hf", 32'(link.head_flit), 0);
    chk("t5_hv", 32'(link.head_valid), 1);
    step();
    chk("t5_none", 32'({link.route_eject, link.route_local, link.route_remote}), 0);
    link.head_ready = 1'b0;
    step();

    // Reset mid-stream with 3 queued and a credit pending
    fill4(20'h40000);
    link.head_ready = 1'b1;
    step();
    link.head_ready = 1'b0;
    chk("t6_occ3", 32'(occupancy), 3);
    chk("t6_crp", 32'(link.credit_out), 1);
    #2;
    rst    = 1'b1;
    inv_en = 1'b0;
    #1;
    check_idle("t6_async");
    chk("t6_ovf", 32'(overflow_err), 0);
    step();
    check_idle("t6_held");
    rst       = 1'b0;
    s_credits = DEPTH;
    inv_en    = 1'b1;

    // Stream 8 flits through, wrapping the pointers twice
    n_credits = 0;
    link.head_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      link.in_flit  = 20'h50000 + 20'(i);
      link.in_valid = 1'b1;
      step();
      if (link.credit_out) n_credits++;
      chk("t6_head", 32'(link.head_flit), 32'h50000 + 32'(i));
      chk("t6_occ", 32'(occupancy), 1);
    end
    link.in_valid = 1'b0;
    step();
    if (link.credit_out) n_credits++;
    chk("t6_occ_end", 32'(occupancy), 0);
    step();
    chk("t6_cr_end", 32'(link.credit_out), 0);
    chk("t6_credits", 32'(n_credits), 8);
    link.head_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/credit_input_port.md
Name: credit_input_port

Overview:
- Receiving end of the credit-based flit link used between a node's processing element and its router, and between neighbouring routers.
- Accepts 20-bit flits qualified by a valid strobe and buffers them in a FIFO.
- Presents the head flit with a decoded route request to the downstream switch stage.
- Returns a one-cycle credit pulse to the upstream sender for every slot freed, so the sender's credit counter never overruns the buffer.

Parameters:
- DEPTH, 4, buffer slots; equals the upstream sender's initial credit count; power of two, 2 to 16.
- FLIT_W, 20, flit width; field layout below is fixed for 20.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- in_flit  input  20  incoming flit; [19:18] dest cluster, [17:16] dest local, [15:0] payload
- in_valid  input  1  in_flit valid this cycle; sender asserts only while holding a credit
- credit_out  output  1  one-cycle pulse, one freed slot returned to the sender
- my_cluster  input  2  this node's cluster id
- my_local  input  2  this node's local id
- head_flit  output  20  flit at FIFO head
- head_valid  output  1  FIFO non-empty
- route_eject  output  1  head destination equals this node (cluster and local match)
- route_local  output  1  same cluster, different local
- route_remote  output  1  different cluster
- head_ready  input  1  switch consumes the head this cycle when head_valid=1
- occupancy  output  clog2(DEPTH+1)  current entry count
- overflow_err  output  1  sticky; set when a flit arrives with the FIFO full

Behaviour:
- Reset (asynchronous, rst=1):
  - read pointer, write pointer and occupancy go to 0.
  - credit_out, head_valid, route_* and overflow_err go to 0.
  - head_flit goes to 0.
- Write: on a rising clk edge with in_valid=1 and the FIFO not full, in_flit is stored at the write pointer; the write pointer increments modulo DEPTH.
- Read: on a rising clk edge with head_valid=1 and head_ready=1, the head entry is popped; the read pointer increments modulo DEPTH.
- head_ready while empty is ignored: no pop, no credit.
- Output timing:
  - head_flit, head_valid and route_* are combinational from the head entry and the id inputs.
  - A flit written at edge N is visible at the head from edge N onward if the FIFO was empty (1-cycle write-to-head latency).
- Route decode:
  - Exactly one of route_eject, route_local, route_remote is 1 when head_valid=1.
  - All three are 0 when head_valid=0.
- Credit return:
  - credit_out is a registered pulse, high for the one cycle following each pop.
  - Back-to-back pops give a continuous high, one credit per cycle.
  - Credits are never merged or dropped.
- Simultaneous write and pop on the same edge:
  - Permitted, including when the FIFO is full: the pop frees the slot in the same edge, so the write is accepted.
  - Occupancy is unchanged.
  - credit_out pulses next cycle.
- Write when full with no pop (protocol violation):
  - The flit is discarded and FIFO contents are unchanged.
  - overflow_err sets and stays 1 until reset.
  - No credit is generated for the discarded flit.
- Wrap-around: pointers wrap from DEPTH-1 to 0. Full and empty are distinguished by the occupancy counter, not by pointer equality.
- Occupancy: increments on a write without a pop, decrements on a pop without a write; it never exceeds DEPTH and never goes below 0.
- Reset mid-operation: all stored flits are lost. A pending credit pulse is cancelled. The sender is also reset in the same domain and reloads DEPTH credits.
- Credit invariant, checked in the bench: sender credits + occupancy + credits in flight equals DEPTH at every cycle.

Test Plan:
- Reset, then my_cluster=1, my_local=2; single flit 0x6_ABCD (dest cluster 1, local 2) with head_ready=1 -> head_valid the cycle after the write, route_eject=1, head_flit=0x6ABCD; pop; credit_out=1 for exactly one cycle; occupancy returns to 0.
- DEPTH=4, head_ready=0, write 4 flits 0x10001..0x10004 -> occupancy=4, no credit pulses; release head_ready for 4 cycles -> flits popped in order, credit_out high 4 consecutive cycles.
- FIFO full and a write and pop on the same edge -> occupancy stays 4, the new flit is appended, overflow_err stays 0, one credit pulse.
- FIFO full, head_ready=0, write 0x3FFFF -> flit dropped, overflow_err=1 (sticky), contents unchanged, no credit.
- Route decode with my_cluster=2, my_local=0: heads 0x8_0000 -> eject, 0xB_0000 -> local, 0x0_0000 -> remote.
- Assert rst mid-stream with 3 flits queued and a credit pulse pending -> all outputs 0 immediately, occupancy 0, no credit pulse; after release, 8 flits stream through with wrap-around and zero loss.
